// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one external SRAM port between requesters A and B with
// round-robin, hold-limited burst grants and owner-tagged read returns.
module sram_arbiter #(
    parameter int MAX_HOLD   = 1024,
    parameter int RD_LATENCY = 2
) (
    input  logic        Clock,
    input  logic        Resetn,

    input  logic        A_req,
    output logic        A_gnt,
    input  logic [17:0] A_address,
    input  logic [15:0] A_write_data,
    input  logic        A_we_n,
    output logic        A_rd_valid,

    input  logic        B_req,
    output logic        B_gnt,
    input  logic [17:0] B_address,
    input  logic [15:0] B_write_data,
    input  logic        B_we_n,
    output logic        B_rd_valid,

    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    input  logic [15:0] SRAM_read_data,
    output logic [15:0] rd_data
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OWN_A = 2'd1,
        S_OWN_B = 2'd2,
        S_TURN  = 2'd3
    } state_t;

    localparam logic [15:0] HOLD_LAST = 16'(MAX_HOLD - 1);

    state_t                state_q, state_d, pick;
    logic [15:0]           hold_q, hold_d;
    logic                  last_b_q, last_b_d;
    logic [17:0]           addr_q;
    logic [15:0]           wdata_q;
    logic [RD_LATENCY-1:0] vld_q, vld_d;
    logic [RD_LATENCY-1:0] own_b_q, own_b_d;
    logic                  acc_a, acc_b, rd_issue;

    // Tie goes to whoever did not own the port most recently.
    always_comb begin
        pick = S_IDLE;
        if (A_req && B_req) begin
            pick = last_b_q ? S_OWN_A : S_OWN_B;
        end else if (A_req) begin
            pick = S_OWN_A;
        end else if (B_req) begin
            pick = S_OWN_B;
        end
    end

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        last_b_d = last_b_q;
        case (state_q)
            S_OWN_A: begin
                last_b_d = 1'b0;
                if (!A_req || (B_req && hold_q == HOLD_LAST)) begin
                    state_d = S_TURN;
                    hold_d  = '0;
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + 16'd1;
                end
            end
            S_OWN_B: begin
                last_b_d = 1'b1;
                if (!B_req || (A_req && hold_q == HOLD_LAST)) begin
                    state_d = S_TURN;
                    hold_d  = '0;
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + 16'd1;
                end
            end
            default: begin
                state_d = pick;
                hold_d  = '0;
            end
        endcase
    end

    assign acc_a = (state_q == S_OWN_A) && A_req;
    assign acc_b = (state_q == S_OWN_B) && B_req;

    // Outside access cycles the bus parks on the last access to avoid glitches.
    always_comb begin
        SRAM_address    = addr_q;
        SRAM_write_data = wdata_q;
        SRAM_we_n       = 1'b1;
        if (acc_a) begin
            SRAM_address    = A_address;
            SRAM_write_data = A_write_data;
            SRAM_we_n       = A_we_n;
        end else if (acc_b) begin
            SRAM_address    = B_address;
            SRAM_write_data = B_write_data;
            SRAM_we_n       = B_we_n;
        end
    end

    assign rd_issue = (acc_a && A_we_n) || (acc_b && B_we_n);

    always_comb begin
        vld_d      = vld_q << 1;
        vld_d[0]   = rd_issue;
        own_b_d    = own_b_q << 1;
        own_b_d[0] = acc_b;
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= S_IDLE;
            hold_q   <= '0;
            last_b_q <= 1'b1;
            addr_q   <= '0;
            wdata_q  <= '0;
            vld_q    <= '0;
            own_b_q  <= '0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            last_b_q <= last_b_d;
            addr_q   <= SRAM_address;
            wdata_q  <= SRAM_write_data;
            vld_q    <= vld_d;
            own_b_q  <= own_b_d;
        end
    end

    assign A_gnt      = (state_q == S_OWN_A);
    assign B_gnt      = (state_q == S_OWN_B);
    assign A_rd_valid = vld_q[RD_LATENCY-1] && !own_b_q[RD_LATENCY-1];
    assign B_rd_valid = vld_q[RD_LATENCY-1] &&  own_b_q[RD_LATENCY-1];
    assign rd_data    = SRAM_read_data;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: random and directed traffic against a queue-based reference
// of the arbitration rules, with a 2-cycle SRAM model on the external port.
module tb_sram_arbiter;
    localparam int MAX_HOLD = 8;
    localparam int RD_LAT   = 2;

    logic        Clock  = 1'b0;
    logic        Resetn = 1'b0;
    logic        A_req = 1'b0, B_req = 1'b0;
    logic [17:0] A_address = '0, B_address = '0;
    logic [15:0] A_write_data = '0, B_write_data = '0;
    logic        A_we_n = 1'b1, B_we_n = 1'b1;
    logic        A_gnt, B_gnt, A_rd_valid, B_rd_valid;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data, SRAM_read_data, rd_data;
    logic        SRAM_we_n;

    sram_arbiter #(.MAX_HOLD(MAX_HOLD), .RD_LATENCY(RD_LAT)) dut (
        .Clock(Clock), .Resetn(Resetn),
        .A_req(A_req), .A_gnt(A_gnt), .A_address(A_address),
        .A_write_data(A_write_data), .A_we_n(A_we_n), .A_rd_valid(A_rd_valid),
        .B_req(B_req), .B_gnt(B_gnt), .B_address(B_address),
        .B_write_data(B_write_data), .B_we_n(B_we_n), .B_rd_valid(B_rd_valid),
        .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data),
        .SRAM_we_n(SRAM_we_n), .SRAM_read_data(SRAM_read_data), .rd_data(rd_data)
    );

    always #5 Clock = ~Clock;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    logic chk_en = 1'b0;

    always @(posedge Clock) cyc <= cyc + 1;

    function automatic logic [15:0] fill(input logic [7:0] a);
        return {a, ~a} ^ 16'h5A3C;
    endfunction

    // External SRAM: 256 words mirrored over the address space, 2-cycle reads.
    logic [15:0]  sram_mem [256];
    logic [255:0] sram_wr = '0;
    logic [15:0]  sram_p1 = '0, sram_p2 = '0;
    always @(posedge Clock) begin
        if (!SRAM_we_n) begin
            sram_mem[SRAM_address[7:0]] <= SRAM_write_data;
            sram_wr[SRAM_address[7:0]]  <= 1'b1;
        end
        sram_p1 <= sram_wr[SRAM_address[7:0]] ? sram_mem[SRAM_address[7:0]] : fill(SRAM_address[7:0]);
        sram_p2 <= sram_p1;
    end
    assign SRAM_read_data = sram_p2;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: who owns the port, how long, and which reads are pending.
    typedef struct { int owner; int due; logic [15:0] data; } rd_exp_t;
    rd_exp_t     rdq[$];
    logic [36:0] cycq[$];
    logic [15:0] ref_mem [int];
    int          m_owner, m_held, m_last;
    logic [17:0] m_addr;
    logic [15:0] m_wd;

    function automatic void model_reset();
        m_owner = 0;
        m_held  = 0;
        m_last  = 2;
        m_addr  = '0;
        m_wd    = '0;
        rdq.delete();
        cycq.delete();
    endfunction

    function automatic logic [15:0] ref_read(input logic [17:0] a);
        int i = int'(a[7:0]);
        return ref_mem.exists(i) ? ref_mem[i] : fill(a[7:0]);
    endfunction

    function automatic void model_cycle();
        logic        my_req, other_req, we;
        logic [17:0] a;
        logic [15:0] d;
        logic        wen;
        my_req    = (m_owner == 1) ? A_req : B_req;
        other_req = (m_owner == 1) ? B_req : A_req;
        a         = (m_owner == 1) ? A_address : B_address;
        d         = (m_owner == 1) ? A_write_data : B_write_data;
        wen       = (m_owner == 1) ? A_we_n : B_we_n;
        we        = 1'b1;
        if (m_owner != 0 && my_req) begin
            m_addr = a;
            m_wd   = d;
            we     = wen;
            if (!wen) ref_mem[int'(a[7:0])] = d;
            else rdq.push_back('{m_owner, cyc + RD_LAT, ref_read(a)});
        end
        cycq.push_back({m_owner == 1, m_owner == 2, we, m_addr, m_wd});
        if (m_owner != 0) begin
            m_last = m_owner;
            m_held++;
            if (!my_req || (other_req && m_held >= MAX_HOLD)) m_owner = 0;
        end else begin
            m_held = 0;
            if (A_req && B_req) m_owner = (m_last == 1) ? 2 : 1;
            else if (A_req)     m_owner = 1;
            else if (B_req)     m_owner = 2;
        end
    endfunction

    // Monitor: every cycle pop the bus expectation and any read return due now.
    logic [36:0] mon_bus;
    rd_exp_t     mon_rd;
    logic        mon_ea, mon_eb;
    logic [15:0] mon_ed;
    always @(negedge Clock) begin
        if (chk_en && Resetn) begin
            if (cycq.size() > 0) begin
                mon_bus = cycq.pop_front();
                check("bus", 64'({A_gnt, B_gnt, SRAM_we_n, SRAM_address, SRAM_write_data}), 64'(mon_bus));
            end
            mon_ea = 1'b0;
            mon_eb = 1'b0;
            mon_ed = '0;
            if (rdq.size() > 0 && rdq[0].due == cyc) begin
                mon_rd = rdq.pop_front();
                mon_ea = (mon_rd.owner == 1);
                mon_eb = (mon_rd.owner == 2);
                mon_ed = mon_rd.data;
            end
            check("rd_return",
                  64'({A_rd_valid, B_rd_valid, (A_rd_valid | B_rd_valid) ? rd_data : 16'h0}),
                  64'({mon_ea, mon_eb, mon_ed}));
        end
    end

    task automatic drive(input logic ar, input logic [17:0] aa, input logic [15:0] awd, input logic awe,
                         input logic br, input logic [17:0] ba, input logic [15:0] bwd, input logic bwe);
        @(posedge Clock);
        #2;
        A_req = ar; A_address = aa; A_write_data = awd; A_we_n = awe;
        B_req = br; B_address = ba; B_write_data = bwd; B_we_n = bwe;
        model_cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b1, 1'b0, '0, '0, 1'b1);
    endtask

    task automatic release_reset();
        @(negedge Clock);
        #1 Resetn = 1'b1;
        model_reset();
        chk_en = 1'b1;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_gnt"}, 64'({A_gnt, B_gnt}), 64'(2'b00));
        check({tag, "_rdv"}, 64'({A_rd_valid, B_rd_valid}), 64'(2'b00));
        check({tag, "_bus"}, 64'({SRAM_we_n, SRAM_address, SRAM_write_data}), 64'({1'b1, 18'h0, 16'h0}));
    endtask

    logic ar_r = 1'b0, br_r = 1'b0;

    initial begin
        repeat (3) @(posedge Clock);
        #1 reset_checks("reset");
        release_reset();

        // Simultaneous first requests: A must win the first tie.
        for (int i = 0; i < 6; i++) drive(1'b1, 18'(100 + i), '0, 1'b1, 1'b1, 18'h200, 16'(16'hB000 + i), 1'b0);
        for (int i = 0; i < 6; i++) drive(1'b0, '0, '0, 1'b1, 1'b1, 18'(18'h210 + i), 16'(16'hB100 + i), 1'b0);
        idle(4);

        // A alone reads 0..9.
        for (int i = 0; i <= 10; i++) drive(1'b1, 18'((i == 0) ? 0 : i - 1), '0, 1'b1, 1'b0, '0, '0, 1'b1);
        idle(4);

        // Contention with preemption, then A alone past the hold limit, then B returns.
        for (int i = 0; i < 25; i++) drive(1'b1, 18'(18'h210 + (i % 6)), '0, 1'b1, 1'b1, 18'(18'h40 + i), 16'(16'hC000 + i), 1'b0);
        for (int i = 0; i < 20; i++) drive(1'b1, 18'(18'h40 + i), '0, 1'b1, 1'b0, '0, '0, 1'b1);
        for (int i = 0; i < 12; i++) drive(1'b1, 18'(18'h40 + i), '0, 1'b1, 1'b1, 18'(18'h80 + i), 16'(16'hD000 + i), 1'b0);
        idle(4);

        // Owner drops req with we_n low: no write may reach the SRAM.
        for (int i = 0; i < 3; i++) drive(1'b1, 18'h300, 16'hBEEF, 1'b0, 1'b0, '0, '0, 1'b1);
        drive(1'b0, 18'h3FF, 16'hDEAD, 1'b0, 1'b0, '0, '0, 1'b1);
        idle(2);
        for (int i = 0; i < 3; i++) drive(1'b1, (i == 2) ? 18'h3FF : 18'h300, '0, 1'b1, 1'b0, '0, '0, 1'b1);
        idle(4);

        // Random bursty traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) ar_r = ~ar_r;
            if ($urandom_range(0, 7) == 0) br_r = ~br_r;
            drive(ar_r, 18'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                  br_r, 18'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        end
        idle(6);

        // Reset in the middle of a read burst with reads in flight.
        for (int i = 0; i < 6; i++) drive(1'b1, 18'(18'h20 + i), '0, 1'b1, 1'b0, '0, '0, 1'b1);
        @(posedge Clock);
        #3;
        check("pre_rst_rdv", 64'(A_rd_valid), 64'(1'b1));
        chk_en = 1'b0;
        Resetn = 1'b0;
        A_req  = 1'b0;
        B_req  = 1'b0;
        #1 reset_checks("midrst");
        repeat (2) @(posedge Clock);
        release_reset();
        idle(10);

        @(negedge Clock);
        #1;
        check("rd_drained", 64'(rdq.size()), 64'(0));
        check("bus_drained", 64'(cycq.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

endmodule
